regfile_sb: RTL and testbench

Parametrised register file with pending-write scoreboard and hardware clear sequencer for the decode stage. It is the successor to the fixed 32x32 register file, and provides:
- configurable width and depth;
- two combinational read ports with optional write-to-read bypass;
- optional hardwired zero register;
- a per-register pending bit that lets decode stall on in-flight producers;
- a multi-cycle clear sequence that zeroes the file without asserting reset.

---
 rtl/regfile_sb.sv | 136 +++++++++++++
 tb/tb_regfile_sb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with pending-write scoreboard and clear sequencer
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] iRAddr1,
    input  logic [ADDR_W-1:0] iRAddr2,
    output logic [DATA_W-1:0] oData1,
    output logic [DATA_W-1:0] oData2,
    output logic              oBusy1,
    output logic              oBusy2,
    input  logic [ADDR_W-1:0] iWAddr,
    input  logic [DATA_W-1:0] iWData,
    input  logic              we,
    input  logic [ADDR_W-1:0] iIssueAddr,
    input  logic              iIssue,
    input  logic              iClear,
    output logic              oClearing,
    output logic              oClearDone
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state, stateNext;
    logic [ADDR_W-1:0] ptr, ptrNext;
    logic              clearDoneNext;
    logic              wrEn, issueEn, clrEn;
    logic              hit1, hit2;

    logic [DATA_W-1:0] buff [DEPTH];
    logic [DEPTH-1:0]  pending;

    function automatic logic isZeroReg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        stateNext     = state;
        ptrNext       = ptr;
        clearDoneNext = 1'b0;
        wrEn          = 1'b0;
        issueEn       = 1'b0;
        clrEn         = 1'b0;
        case (state)
            IDLE: begin
                wrEn    = we && !isZeroReg(iWAddr);
                issueEn = iIssue && !isZeroReg(iIssueAddr);
                if (iClear) begin
                    stateNext = CLEAR;
                    ptrNext   = '0;
                end
            end
            CLEAR: begin
                clrEn   = 1'b1;
                ptrNext = ptr + ADDR_W'(1);
                if (ptr == {ADDR_W{1'b1}}) begin
                    stateNext     = IDLE;
                    clearDoneNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            oClearing  <= 1'b0;
            oClearDone <= 1'b0;
        end else begin
            state      <= stateNext;
            ptr        <= ptrNext;
            oClearing  <= (stateNext == CLEAR);
            oClearDone <= clearDoneNext;
        end
    end

    // Issue is applied after the write so a same-cycle issue keeps the register pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buff[i] <= '0;
            end
            pending <= '0;
        end else if (clrEn) begin
            buff[ptr]    <= '0;
            pending[ptr] <= 1'b0;
        end else begin
            if (wrEn) begin
                buff[iWAddr]    <= iWData;
                pending[iWAddr] <= 1'b0;
            end
            if (issueEn) begin
                pending[iIssueAddr] <= 1'b1;
            end
        end
    end

    assign hit1 = (BYPASS != 0) && (state == IDLE) && we && (iWAddr == iRAddr1);
    assign hit2 = (BYPASS != 0) && (state == IDLE) && we && (iWAddr == iRAddr2);

    always_comb begin
        oData1 = buff[iRAddr1];
        oBusy1 = pending[iRAddr1];
        if (isZeroReg(iRAddr1)) begin
            oData1 = '0;
            oBusy1 = 1'b0;
        end else if (hit1) begin
            oData1 = iWData;
            oBusy1 = iIssue && (iIssueAddr == iRAddr1);
        end
    end

    always_comb begin
        oData2 = buff[iRAddr2];
        oBusy2 = pending[iRAddr2];
        if (isZeroReg(iRAddr2)) begin
            oData2 = '0;
            oBusy2 = 1'b0;
        end else if (hit2) begin
            oData2 = iWData;
            oBusy2 = iIssue && (iIssueAddr == iRAddr2);
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  rAddr1, rAddr2, wAddr, issueAddr;
    logic [31:0] wData;
    logic        we, issue, clear;
    logic [31:0] data1, data2, nbData1, nbData2;
    logic        busy1, busy2, clearing, clearDone;
    logic        nbBusy1, nbBusy2, nbClearing, nbClearDone;

    logic [2:0]  sRAddr1, sRAddr2, sWAddr, sIssueAddr;
    logic [15:0] sWData, sData1, sData2;
    logic        sWe, sIssue, sClear;
    logic        sBusy1, sBusy2, sClearing, sClearDone;

    int nVec = 0;
    int nMis = 0;
    int cnt, done, doneAt, nz;

    regfile_sb dut (
        .clk(clk), .reset(reset),
        .iRAddr1(rAddr1), .iRAddr2(rAddr2), .oData1(data1), .oData2(data2),
        .oBusy1(busy1), .oBusy2(busy2),
        .iWAddr(wAddr), .iWData(wData), .we(we),
        .iIssueAddr(issueAddr), .iIssue(issue), .iClear(clear),
        .oClearing(clearing), .oClearDone(clearDone)
    );

    regfile_sb #(.BYPASS(0)) dutNb (
        .clk(clk), .reset(reset),
        .iRAddr1(rAddr1), .iRAddr2(rAddr2), .oData1(nbData1), .oData2(nbData2),
        .oBusy1(nbBusy1), .oBusy2(nbBusy2),
        .iWAddr(wAddr), .iWData(wData), .we(we),
        .iIssueAddr(issueAddr), .iIssue(issue), .iClear(clear),
        .oClearing(nbClearing), .oClearDone(nbClearDone)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dutSmall (
        .clk(clk), .reset(reset),
        .iRAddr1(sRAddr1), .iRAddr2(sRAddr2), .oData1(sData1), .oData2(sData2),
        .oBusy1(sBusy1), .oBusy2(sBusy2),
        .iWAddr(sWAddr), .iWData(sWData), .we(sWe),
        .iIssueAddr(sIssueAddr), .iIssue(sIssue), .iClear(sClear),
        .oClearing(sClearing), .oClearDone(sClearDone)
    );

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        rAddr1 = '0; rAddr2 = '0; wAddr = '0; issueAddr = '0; wData = '0;
        we = 1'b0; issue = 1'b0; clear = 1'b0;
        sRAddr1 = '0; sRAddr2 = '0; sWAddr = '0; sIssueAddr = '0; sWData = '0;
        sWe = 1'b0; sIssue = 1'b0; sClear = 1'b0;
        tick(); tick();
        rAddr1 = 5'd5;
        #1;
        checkEq("rst_data1", data1, 0);
        checkEq("rst_busy1", busy1, 0);
        checkEq("rst_clearing", clearing, 0);
        checkEq("rst_done", clearDone, 0);
        reset = 1'b1;
        tick();

        // write / read back, zero register
        we = 1'b1; wAddr = 5'd5; wData = 32'hDEADBEEF;
        tick();
        we = 1'b0; rAddr1 = 5'd5;
        #1 checkEq("wr_r5", data1, 32'hDEADBEEF);
        we = 1'b1; wAddr = 5'd0; wData = 32'h1234; rAddr2 = 5'd0;
        #1 checkEq("r0_no_bypass", data2, 0);
        tick();
        we = 1'b0; rAddr1 = 5'd0;
        #1 checkEq("r0_reads_zero", data1, 0);

        // bypass
        we = 1'b1; wAddr = 5'd7; wData = 32'hA5A5A5A5; rAddr2 = 5'd7;
        #1;
        checkEq("bypass_data2", data2, 32'hA5A5A5A5);
        checkEq("nobypass_old", nbData2, 0);
        tick();
        we = 1'b0;
        #1 checkEq("nobypass_after", nbData2, 32'hA5A5A5A5);

        // scoreboard
        issue = 1'b1; issueAddr = 5'd9; rAddr1 = 5'd9;
        #1 checkEq("issue_same_cycle", busy1, 0);
        tick();
        issue = 1'b0;
        #1 checkEq("issue_next", busy1, 1);
        tick();
        #1 checkEq("issue_hold", busy1, 1);
        we = 1'b1; wAddr = 5'd9; wData = 32'h99;
        #1;
        checkEq("wr_busy_bypass", busy1, 0);
        checkEq("wr_busy_nobyp", nbBusy1, 1);
        tick();
        we = 1'b0;
        #1;
        checkEq("wr_busy_after", busy1, 0);
        checkEq("wr_data_r9", data1, 32'h99);
        we = 1'b1; wAddr = 5'd9; wData = 32'h77; issue = 1'b1; issueAddr = 5'd9;
        #1 checkEq("iss_wr_bypass", busy1, 1);
        tick();
        we = 1'b0; issue = 1'b0;
        #1;
        checkEq("iss_wr_pending", busy1, 1);
        checkEq("iss_wr_data", data1, 32'h77);
        issue = 1'b1; issueAddr = 5'd0;
        tick();
        issue = 1'b0; rAddr1 = 5'd0;
        #1 checkEq("r0_never_busy", busy1, 0);

        // full clear
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wAddr = 5'(i); wData = 32'h1000_0000 + 32'(i);
            tick();
        end
        we = 1'b0;
        issue = 1'b1; issueAddr = 5'd3;
        tick();
        issue = 1'b0; rAddr1 = 5'd31; rAddr2 = 5'd3;
        #1;
        checkEq("fill_r31", data1, 32'h1000_001F);
        checkEq("fill_r3_busy", busy2, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cnt = 0; done = 0; doneAt = 0;
        for (int c = 1; c <= 40; c++) begin
            we = (c == 10); wAddr = 5'd2; wData = 32'hFFFF;
            issue = (c == 10); issueAddr = 5'd2;
            clear = (c == 10);
            rAddr1 = 5'd31; rAddr2 = 5'd2;
            #1;
            if (clearing) cnt++;
            if (clearDone) begin done++; doneAt = c; end
            if (c == 1) checkEq("clr_first_cycle", clearing, 1);
            if (c == 10) begin
                checkEq("clr_partial_r31", data1, 32'h1000_001F);
                checkEq("clr_no_bypass", data2, 0);
            end
            if (c == 11) begin
                checkEq("clr_we_ignored", data2, 0);
                checkEq("clr_iss_ignored", busy2, 0);
            end
            tick();
        end
        we = 1'b0; issue = 1'b0; clear = 1'b0;
        checkEq("clr_cycles", cnt, 32);
        checkEq("clr_done_count", done, 1);
        checkEq("clr_done_at", doneAt, 33);
        nz = 0;
        for (int i = 0; i < 32; i++) begin
            rAddr1 = 5'(i);
            #1;
            if (data1 !== 32'h0 || busy1 !== 1'b0) nz++;
        end
        checkEq("clr_all_zero", nz, 0);

        // reset mid-clear
        we = 1'b1; wAddr = 5'd4; wData = 32'h44;
        tick();
        wAddr = 5'd31; wData = 32'h31;
        tick();
        we = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        #1 checkEq("mid_clearing", clearing, 1);
        reset = 1'b0;
        rAddr1 = 5'd31; rAddr2 = 5'd4;
        #1;
        checkEq("abort_clearing", clearing, 0);
        checkEq("abort_r31", data1, 0);
        checkEq("abort_r4", data2, 0);
        tick();
        reset = 1'b1;
        cnt = 0; done = 0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (clearing) cnt++;
            if (clearDone) done++;
            tick();
        end
        checkEq("abort_no_clearing", cnt, 0);
        checkEq("abort_no_done", done, 0);
        we = 1'b1; wAddr = 5'd6; wData = 32'h600D;
        tick();
        we = 1'b0; rAddr1 = 5'd6;
        #1 checkEq("resume_write", data1, 32'h600D);

        // small configuration: r0 writable and pendable, 8-cycle clear
        sWe = 1'b1; sWAddr = 3'd0; sWData = 16'hBEEF;
        tick();
        sWe = 1'b0; sRAddr1 = 3'd0;
        #1 checkEq("s_r0_write", sData1, 16'hBEEF);
        sIssue = 1'b1; sIssueAddr = 3'd0;
        tick();
        sIssue = 1'b0;
        #1 checkEq("s_r0_busy", sBusy1, 1);
        sWe = 1'b1; sWAddr = 3'd7; sWData = 16'h7777;
        tick();
        sWe = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            sClear = 1'b1;
            tick();
            sClear = 1'b0;
            cnt = 0; done = 0; doneAt = 0;
            for (int c = 1; c <= 16; c++) begin
                #1;
                if (sClearing) cnt++;
                if (sClearDone) begin done++; doneAt = c; end
                tick();
            end
            checkEq("s_clr_cycles", cnt, 8);
            checkEq("s_clr_done_at", doneAt, 9);
            checkEq("s_clr_done_count", done, 1);
            nz = 0;
            for (int i = 0; i < 8; i++) begin
                sRAddr1 = 3'(i);
                #1;
                if (sData1 !== 16'h0 || sBusy1 !== 1'b0) nz++;
            end
            checkEq("s_clr_all_zero", nz, 0);
            sWe = 1'b1; sWAddr = 3'd0; sWData = 16'h1111;
            tick();
            sWe = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
